// File: rtl/idex_if.sv
// ID/EX stage bus. It carries the upstream fetch/regfile signals in, the
// registered decode entry out to execute, and the flush from branch resolution.
interface idex_if #(
    parameter int XLEN = 32
);
    // Handshake: a transfer happens on a rising edge where valid && ready.
    // valid must not depend on ready. While valid && !ready the payload
    // holds steady. The stage's in_ready_o never looks at in_valid_i.
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            flush_i;

    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] a_o;
    logic [XLEN-1:0] b_o;
    logic [3:0]      alucontrol_o;
    logic [XLEN-1:0] imm_o;
    logic [XLEN-1:0] rs2_data_o;
    logic [XLEN-1:0] pc_o;
    logic [4:0]      rd_o;
    logic            reg_write_o;
    logic            mem_read_o;
    logic            mem_write_o;
    logic            branch_o;
    logic            jump_o;
    logic [2:0]      funct3_o;
    logic            illegal_o;

    // The environment side: it feeds instructions and consumes entries.
    modport master (
        output in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, a_o, b_o, alucontrol_o, imm_o, rs2_data_o,
               pc_o, rd_o, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o,
               funct3_o, illegal_o
    );

    // The stage itself.
    modport slave (
        input  in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, a_o, b_o, alucontrol_o, imm_o, rs2_data_o,
               pc_o, rd_o, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o,
               funct3_o, illegal_o
    );
endinterface

// File: rtl/idex_stage.sv
// RV32I decode/issue stage. It decodes ALU control, builds the immediate and
// selects the operands, then holds them in a one-entry ID/EX register in front of the ALU.
module idex_stage #(
    parameter int XLEN = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    idex_if.slave  bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] pc;
        logic [3:0]      alu;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            illegal;
    } entry_t;

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_u;
    logic            reg_write_d;

    entry_t entry_d;
    entry_t entry_q;
    logic   valid_q;
    logic   accept;

    assign instr  = bus.instr_i;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rd     = instr[11:7];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    always_comb begin
        entry_d          = '0;
        reg_write_d      = 1'b0;
        entry_d.rs2_data = bus.rs2_data_i;
        entry_d.pc       = bus.pc_i;
        entry_d.rd       = rd;
        entry_d.funct3   = funct3;
        entry_d.alu      = ALU_ADD;

        case (opcode)
            OPC_OP: begin
                entry_d.a   = bus.rs1_data_i;
                entry_d.b   = bus.rs2_data_i;
                entry_d.alu = {instr[30], funct3};
                reg_write_d = 1'b1;
            end
            OPC_OP_IMM: begin
                // Bit 30 only selects SRAI over SRLI; elsewhere it is immediate data.
                entry_d.a   = bus.rs1_data_i;
                entry_d.b   = imm_i;
                entry_d.imm = imm_i;
                entry_d.alu = {instr[30] && (funct3 == 3'b101), funct3};
                reg_write_d = 1'b1;
            end
            OPC_LOAD: begin
                entry_d.a        = bus.rs1_data_i;
                entry_d.b        = imm_i;
                entry_d.imm      = imm_i;
                entry_d.mem_read = 1'b1;
                reg_write_d      = 1'b1;
            end
            OPC_STORE: begin
                entry_d.a         = bus.rs1_data_i;
                entry_d.b         = imm_s;
                entry_d.imm       = imm_s;
                entry_d.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                entry_d.a      = bus.rs1_data_i;
                entry_d.b      = bus.rs2_data_i;
                entry_d.imm    = imm_b;
                entry_d.branch = 1'b1;
                case (funct3[2:1])
                    2'b10:   entry_d.alu = ALU_SLT;
                    2'b11:   entry_d.alu = ALU_SLTU;
                    default: entry_d.alu = ALU_SUB;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                // The ALU computes the link value pc+4; the target offset rides on imm.
                entry_d.a    = bus.pc_i;
                entry_d.b    = XLEN'(4);
                entry_d.imm  = (opcode == OPC_JAL) ? imm_j : imm_i;
                entry_d.jump = 1'b1;
                reg_write_d  = 1'b1;
            end
            OPC_LUI: begin
                entry_d.b   = imm_u;
                entry_d.imm = imm_u;
                reg_write_d = 1'b1;
            end
            OPC_AUIPC: begin
                entry_d.a   = bus.pc_i;
                entry_d.b   = imm_u;
                entry_d.imm = imm_u;
                reg_write_d = 1'b1;
            end
            default: begin
                entry_d.illegal = 1'b1;
            end
        endcase

        entry_d.reg_write = reg_write_d && (rd != 5'd0);
    end

    // Gating with rst_n stops upstream from counting a transfer while the stage is held in reset.
    assign bus.in_ready_o = rst_n && (!valid_q || bus.out_ready_i);
    assign accept         = bus.in_valid_i && bus.in_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (bus.flush_i) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
        end else if (bus.out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // The payload still loads on a flushed accept. This is harmless because valid_q stays low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (accept) begin
            entry_q <= entry_d;
        end
    end

    assign bus.out_valid_o  = valid_q;
    assign bus.a_o          = entry_q.a;
    assign bus.b_o          = entry_q.b;
    assign bus.alucontrol_o = entry_q.alu;
    assign bus.imm_o        = entry_q.imm;
    assign bus.rs2_data_o   = entry_q.rs2_data;
    assign bus.pc_o         = entry_q.pc;
    assign bus.rd_o         = entry_q.rd;
    assign bus.reg_write_o  = entry_q.reg_write;
    assign bus.mem_read_o   = entry_q.mem_read;
    assign bus.mem_write_o  = entry_q.mem_write;
    assign bus.branch_o     = entry_q.branch;
    assign bus.jump_o       = entry_q.jump;
    assign bus.funct3_o     = entry_q.funct3;
    assign bus.illegal_o    = entry_q.illegal;

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: decode vectors, backpressure, flush and
// mid-stall reset. The expected values are worked out by hand from the RV32I encodings.
module tb_idex_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    idex_if #(.XLEN(32)) bus ();

    idex_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {reg_write, mem_read, mem_write, branch, jump, illegal}
    function automatic logic [5:0] flags();
        return {bus.reg_write_o, bus.mem_read_o, bus.mem_write_o,
                bus.branch_o, bus.jump_o, bus.illegal_o};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid_i = 1'b1;
        bus.instr_i    = instr;
        bus.pc_i       = pc;
        bus.rs1_data_i = rs1;
        bus.rs2_data_i = rs2;
    endtask

    // Presents one instruction for one cycle. Returns on the negedge where it sits in ID/EX.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        @(negedge clk);
        drive(instr, pc, rs1, rs2);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", bus.out_valid_o); end
        n_cmp++; if ({bus.a_o, bus.b_o, bus.alucontrol_o} !== 68'h0) begin n_err++; $display("FAIL rst_data got %h/%h/%h want 0", bus.a_o, bus.b_o, bus.alucontrol_o); end
        n_cmp++; if (flags() !== 6'b000000) begin n_err++; $display("FAIL rst_flags got %b want 000000", flags()); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0b want 1", bus.in_ready_o); end
    endtask

    task automatic test_alu_ops();
        issue(32'h002081B3, 32'h1000, 32'd5, 32'd7);     // add x3,x1,x2
        n_cmp++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL add_valid got %0b want 1", bus.out_valid_o); end
        n_cmp++; if ({bus.a_o, bus.b_o} !== {32'd5, 32'd7}) begin n_err++; $display("FAIL add_ops got %h/%h want 5/7", bus.a_o, bus.b_o); end
        n_cmp++; if ({bus.alucontrol_o, bus.rd_o, flags()} !== {4'b0000, 5'd3, 6'b100000}) begin n_err++; $display("FAIL add_ctl got %b/%0d/%b want 0000/3/100000", bus.alucontrol_o, bus.rd_o, flags()); end

        issue(32'h402081B3, 32'h1004, 32'd20, 32'd7);    // sub x3,x1,x2
        n_cmp++; if ({bus.alucontrol_o, bus.a_o, bus.b_o} !== {4'b1000, 32'd20, 32'd7}) begin n_err++; $display("FAIL sub got %b/%h/%h want 1000/14/7", bus.alucontrol_o, bus.a_o, bus.b_o); end

        issue(32'h40435293, 32'h1008, 32'h80000000, 32'h0);  // srai x5,x6,4
        n_cmp++; if ({bus.alucontrol_o, bus.b_o, bus.rd_o} !== {4'b1101, 32'h404, 5'd5}) begin n_err++; $display("FAIL srai got %b/%h/%0d want 1101/404/5", bus.alucontrol_o, bus.b_o, bus.rd_o); end
        n_cmp++; if (bus.a_o !== 32'h80000000) begin n_err++; $display("FAIL srai_a got %h want 80000000", bus.a_o); end

        issue(32'h40000093, 32'h100C, 32'h0, 32'h0);     // addi x1,x0,0x400 (bit30 set)
        n_cmp++; if ({bus.alucontrol_o, bus.b_o} !== {4'b0000, 32'h400}) begin n_err++; $display("FAIL addi_b30 got %b/%h want 0000/400", bus.alucontrol_o, bus.b_o); end

        issue(32'hFFF00093, 32'h1010, 32'h0, 32'h0);     // addi x1,x0,-1
        n_cmp++; if ({bus.b_o, bus.imm_o} !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin n_err++; $display("FAIL addi_neg got %h/%h want ffffffff/ffffffff", bus.b_o, bus.imm_o); end
    endtask

    task automatic test_classes();
        issue(32'h123450B7, 32'h2000, 32'h55, 32'h0);    // lui x1,0x12345
        n_cmp++; if ({bus.a_o, bus.b_o, bus.rd_o, flags()} !== {32'h0, 32'h12345000, 5'd1, 6'b100000}) begin n_err++; $display("FAIL lui got %h/%h/%0d/%b", bus.a_o, bus.b_o, bus.rd_o, flags()); end

        issue(32'h0020A423, 32'h2004, 32'h300, 32'hDEADBEEF);  // sw x2,8(x1)
        n_cmp++; if ({bus.a_o, bus.b_o, bus.imm_o} !== {32'h300, 32'h8, 32'h8}) begin n_err++; $display("FAIL sw_ops got %h/%h/%h want 300/8/8", bus.a_o, bus.b_o, bus.imm_o); end
        n_cmp++; if ({flags(), bus.funct3_o, bus.rs2_data_o} !== {6'b001000, 3'b010, 32'hDEADBEEF}) begin n_err++; $display("FAIL sw_ctl got %b/%b/%h", flags(), bus.funct3_o, bus.rs2_data_o); end

        issue(32'hFF80A103, 32'h2008, 32'h400, 32'h0);   // lw x2,-8(x1)
        n_cmp++; if ({bus.b_o, bus.alucontrol_o, bus.rd_o, flags()} !== {32'hFFFFFFF8, 4'b0000, 5'd2, 6'b110000}) begin n_err++; $display("FAIL lw got %h/%b/%0d/%b", bus.b_o, bus.alucontrol_o, bus.rd_o, flags()); end

        issue(32'h0020C863, 32'h200C, 32'd3, 32'd9);     // blt x1,x2,+16
        n_cmp++; if ({bus.a_o, bus.b_o, bus.imm_o} !== {32'd3, 32'd9, 32'd16}) begin n_err++; $display("FAIL blt_ops got %h/%h/%h want 3/9/10", bus.a_o, bus.b_o, bus.imm_o); end
        n_cmp++; if ({bus.alucontrol_o, flags(), bus.funct3_o} !== {4'b0010, 6'b000100, 3'b100}) begin n_err++; $display("FAIL blt_ctl got %b/%b/%b", bus.alucontrol_o, flags(), bus.funct3_o); end

        issue(32'h008000EF, 32'h100, 32'h77, 32'h0);     // jal x1,+8
        n_cmp++; if ({bus.a_o, bus.b_o, bus.imm_o, bus.pc_o} !== {32'h100, 32'h4, 32'h8, 32'h100}) begin n_err++; $display("FAIL jal_ops got %h/%h/%h/%h", bus.a_o, bus.b_o, bus.imm_o, bus.pc_o); end
        n_cmp++; if ({flags(), bus.rd_o} !== {6'b100010, 5'd1}) begin n_err++; $display("FAIL jal_ctl got %b/%0d want 100010/1", flags(), bus.rd_o); end

        issue(32'hFFDFF06F, 32'h200, 32'h0, 32'h0);      // jal x0,-4
        n_cmp++; if ({bus.imm_o, flags(), bus.rd_o} !== {32'hFFFFFFFC, 6'b000010, 5'd0}) begin n_err++; $display("FAIL jal_x0 got %h/%b/%0d want fffffffc/000010/0", bus.imm_o, flags(), bus.rd_o); end

        issue(32'h00C280E7, 32'h300, 32'h999, 32'h0);    // jalr x1,12(x5)
        n_cmp++; if ({bus.a_o, bus.b_o, bus.imm_o, flags()} !== {32'h300, 32'h4, 32'hC, 6'b100010}) begin n_err++; $display("FAIL jalr got %h/%h/%h/%b", bus.a_o, bus.b_o, bus.imm_o, flags()); end

        issue(32'h00001197, 32'h400, 32'h0, 32'h0);      // auipc x3,1
        n_cmp++; if ({bus.a_o, bus.b_o, bus.rd_o} !== {32'h400, 32'h1000, 5'd3}) begin n_err++; $display("FAIL auipc got %h/%h/%0d want 400/1000/3", bus.a_o, bus.b_o, bus.rd_o); end

        issue(32'h0000007F, 32'h500, 32'h11, 32'h22);    // unsupported opcode
        n_cmp++; if ({bus.out_valid_o, flags(), bus.alucontrol_o} !== {1'b1, 6'b000001, 4'b0000}) begin n_err++; $display("FAIL illegal_ctl got %b/%b/%b want 1/000001/0000", bus.out_valid_o, flags(), bus.alucontrol_o); end
        n_cmp++; if ({bus.a_o, bus.b_o} !== 64'h0) begin n_err++; $display("FAIL illegal_ops got %h/%h want 0/0", bus.a_o, bus.b_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals = '{32'hB0, 32'hC0, 32'hD0, 32'hE0};
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        issue(32'h00000093, 32'h600, 32'hA0, 32'h0);
        drive(32'h00000093, 32'h604, vals[0], 32'h0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d] got %0b want 0", i, bus.in_ready_o); end
            n_cmp++; if ({bus.out_valid_o, bus.a_o} !== {1'b1, 32'hA0}) begin n_err++; $display("FAIL stall_hold[%0d] got %0b/%h want 1/a0", i, bus.out_valid_o, bus.a_o); end
            @(negedge clk);
        end
        bus.out_ready_i = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready_o !== 1'b1) begin n_err++; $display("FAIL release_ready got %0b want 1", bus.in_ready_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if ({bus.out_valid_o, bus.a_o} !== {1'b1, vals[i]}) begin n_err++; $display("FAIL b2b[%0d] got %0b/%h want 1/%h", i, bus.out_valid_o, bus.a_o, vals[i]); end
            if (i < 3) bus.rs1_data_i = vals[i+1];
            else       bus.in_valid_i = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_valid got %0b want 0", bus.out_valid_o); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        issue(32'h00000093, 32'h700, 32'h111, 32'h0);
        bus.out_ready_i = 1'b1;
        bus.flush_i     = 1'b1;
        drive(32'h00000093, 32'h704, 32'h222, 32'h0);
        @(negedge clk);
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b want 0", bus.out_valid_o); end
        @(negedge clk);
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_ghost got %0b/%h want 0", bus.out_valid_o, bus.a_o); end
        issue(32'h00000093, 32'h708, 32'h333, 32'h0);
        n_cmp++; if ({bus.out_valid_o, bus.a_o} !== {1'b1, 32'h333}) begin n_err++; $display("FAIL flush_recover got %0b/%h want 1/333", bus.out_valid_o, bus.a_o); end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        issue(32'h00000093, 32'h800, 32'h444, 32'h0);
        drive(32'h00000093, 32'h804, 32'h555, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.out_valid_o, bus.a_o} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL midrst_async got %0b/%h want 0/0", bus.out_valid_o, bus.a_o); end
        repeat (2) @(negedge clk);
        rst_n          = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_capture got %0b want 0", bus.out_valid_o); end
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.instr_i     = '0;
        bus.pc_i        = '0;
        bus.rs1_data_i  = '0;
        bus.rs2_data_i  = '0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        test_reset();
        test_alu_ops();
        test_classes();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- Decode/issue stage sitting directly upstream of the execute-stage ALU.
- Accepts a fetched RV32I instruction, its PC and the register-file read data for rs1/rs2.
- Decodes the 4-bit ALU control code, generates the immediate and selects ALU operands A/B.
- Holds the result in a one-entry ID/EX pipeline register with valid/ready handshake and flush, so the ALU consumes registered operands.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  instruction/operands valid this cycle.
- in_ready_o  output  1  stage can accept this cycle.
- instr_i  input  32  instruction word.
- pc_i  input  32  PC of the instruction.
- rs1_data_i  input  32  register-file value of rs1.
- rs2_data_i  input  32  register-file value of rs2.
- flush_i  input  1  kill the held entry and any same-cycle accept (branch redirect).
- out_valid_o  output  1  registered entry valid.
- out_ready_i  input  1  execute stage consumes the entry this cycle.
- a_o  output  32  ALU operand A.
- b_o  output  32  ALU operand B.
- alucontrol_o  output  4  ALU operation code.
- imm_o  output  32  sign-extended immediate (branch/jump offset, store offset).
- rs2_data_o  output  32  store data.
- pc_o  output  32  PC passthrough.
- rd_o  output  5  destination register.
- reg_write_o  output  1  writes rd (forced 0 when rd==0).
- mem_read_o, mem_write_o, branch_o, jump_o  output  1 each  class flags.
- funct3_o  output  3  passthrough for branch condition and memory size.
- illegal_o  output  1  unsupported opcode.

Behaviour:
- Reset (asynchronous, rst_n low): out_valid_o=0; all other registered outputs 0. Released synchronously with clk.
- ALU codes: ADD 0000, SUB 1000, SLT 0010, SLTU 0011, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101, SRA 1101.
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i; combinational, and does not depend on in_valid_i.
  - Accept = in_valid_i && in_ready_o. Latency is 1 cycle: the accepted instruction appears on the outputs the next cycle with out_valid_o=1.
  - Outputs stay stable while out_valid_o && !out_ready_i.
  - Simultaneous consume and accept gives back-to-back throughput of 1 instr/cycle.
  - Consume without accept: out_valid_o falls to 0.
- Flush has priority: flush_i=1 clears out_valid_o next cycle and discards any same-cycle accept. The data registers may update, but they are don't-care while invalid.
- Decode, by opcode instr[6:0]:
  - 0110011 OP: a=rs1, b=rs2, alu={instr[30],funct3}, reg_write.
  - 0010011 OP-IMM: a=rs1, b=imm_I, alu={instr[30]&&(funct3==101), funct3}. Bit 30 is ignored for all other funct3, so ADDI never becomes SUB.
  - 0000011 LOAD: a=rs1, b=imm_I, ADD, mem_read, reg_write.
  - 0100011 STORE: a=rs1, b=imm_S, ADD, mem_write.
  - 1100011 BRANCH: a=rs1, b=rs2, branch. funct3 00x gives SUB; 10x gives SLT; 11x gives SLTU.
  - 1101111 JAL / 1100111 JALR: a=pc, b=4, ADD (link value), jump, reg_write. imm_o carries imm_J / imm_I respectively.
  - 0110111 LUI: a=0, b=imm_U, ADD, reg_write.
  - 0010111 AUIPC: a=pc, b=imm_U, ADD, reg_write.
  - Any other opcode: illegal_o=1, all class flags and reg_write 0, alu=ADD, a=b=0. The entry still flows with out_valid_o=1.
- Immediates: I/S/B/J are sign-extended from instr[31]. B/J have bit 0 = 0. U = {instr[31:12],12'b0}.
- rd_o = instr[11:7] for all types. reg_write_o=0 when rd==0.
- Reset mid-operation: the held entry is lost immediately (out_valid_o=0), and no handshake occurs until reset is released.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3, rs1=5, rs2=7) -> next cycle out_valid_o=1, a=5, b=7, alu=0000, rd=3, reg_write=1.
- SUB 0x402081B3 -> alu=1000. SRAI x5,x6,4 (0x40435293) -> alu=1101, b=0x00000404. ADDI x1,x0,0x400 (0x40000093) -> alu=0000, b=0x400.
- ADDI 0xFFF00093 -> b=0xFFFFFFFF. LUI 0x123450B7 -> a=0, b=0x12345000. SW 0x0020A423 -> b=imm_o=8, mem_write=1, reg_write=0.
- Backpressure: hold out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0, outputs stable. Release -> 4 back-to-back instructions emerge in order, 1 per cycle.
- Flush with the entry held and a same-cycle accept -> out_valid_o=0 next cycle, and the flushed instruction never appears.
- Opcode 0x0000007F -> illegal_o=1, reg_write=0, out_valid_o=1. Assert rst_n low mid-stall -> out_valid_o=0 immediately.
